// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter
//
// Clocked round-robin arbiter that lets `size` four-phase requesters share one
// four-phase req/ack channel. Complete handshakes are serialised, one requester
// at a time. After a requester wins, it has the lowest priority.
//
// Ports:
//   clk        system clock, rising edge active
//   rst        asynchronous, active-high reset
//   req_in     four-phase request, one bit per requester
//   ack_in     four-phase acknowledge, one bit per requester (registered)
//   req_out    request to the shared channel (registered)
//   ack_out    acknowledge from the shared channel
//   grant_idx  index of the current/last granted requester (registered)
//   busy       high whenever the controller is not idle (registered)
//
// Configuration macro:
//   ARB_SYNC_EN  when defined, req_in and ack_out each pass through a 2-flop
//                synchroniser before the state machine sees them. Each
//                transition then takes 3 clk instead of 1. When it is not
//                defined, the inputs are sampled directly. Leave it undefined
//                only if the sources are synchronous to clk.

module rr_handshake_arbiter #(
  parameter int size  = 4,
  parameter int IDX_W = (size > 1) ? $clog2(size) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [size-1:0]  req_in,
  output logic [size-1:0]  ack_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACKD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [size-1:0]  rq;
  logic             ak;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] grant_next;
  logic [size-1:0]  ack_in_next;
  logic             req_out_next;
  logic             busy_next;
  logic [IDX_W-1:0] win;
  logic             win_valid;

`ifdef ARB_SYNC_EN
  logic [size-1:0] rq_meta;
  logic            ak_meta;

  // Two-flop synchronisers for the asynchronous handshake inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_meta <= '0;
      rq      <= '0;
      ak_meta <= 1'b0;
      ak      <= 1'b0;
    end else begin
      rq_meta <= req_in;
      rq      <= rq_meta;
      ak_meta <= ack_out;
      ak      <= ak_meta;
    end
  end
`else
  assign rq = req_in;
  assign ak = ack_out;
`endif

  // Round-robin search: try ptr+1, ptr+2, ... with wrap-around. The first set
  // request wins. The previous winner is visited last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = ptr;
    win       = ptr;
    win_valid = 1'b0;
    for (int k = 0; k < size; k++) begin
      cand = (cand == IDX_W'(size - 1)) ? '0 : cand + 1'b1;
      if (!win_valid && rq[cand]) begin
        win       = cand;
        win_valid = 1'b1;
      end
    end
  end

  // State register. The control outputs are registered alongside the state
  // so that they change only on a clock edge or on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDX_W'(size - 1);
      grant_idx <= '0;
      ack_in    <= '0;
      req_out   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      grant_idx <= grant_next;
      ack_in    <= ack_in_next;
      req_out   <= req_out_next;
      busy      <= busy_next;
    end
  end

  // Next-state logic. A drop of rq[w] during GRANT and a drop of ak during ACKD
  // are protocol violations. These states do not look at those inputs, so the
  // violations have no effect.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid)      state_next = GRANT;
      GRANT:   if (ak)             state_next = ACKD;
      ACKD:    if (!rq[grant_idx]) state_next = RELEASE;
      RELEASE: if (!ak)            state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Output logic. This block computes the next registered values. By default
  // each register holds its value, and each transition changes only the
  // registers that it owns.
  always_comb begin
    ptr_next     = ptr;
    grant_next   = grant_idx;
    ack_in_next  = ack_in;
    req_out_next = req_out;
    busy_next    = busy;
    case (state)
      IDLE: begin
        if (win_valid) begin
          grant_next   = win;
          ptr_next     = win;
          req_out_next = 1'b1;
          busy_next    = 1'b1;
        end
      end
      GRANT: begin
        if (ak) begin
          ack_in_next            = '0;
          ack_in_next[grant_idx] = 1'b1;
        end
      end
      ACKD: begin
        if (!rq[grant_idx]) req_out_next = 1'b0;
      end
      RELEASE: begin
        if (!ak) begin
          ack_in_next = '0;
          busy_next   = 1'b0;
        end
      end
      default: begin
        ack_in_next  = '0;
        req_out_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// tb_rr_handshake_arbiter
//
// Self-checking bench for rr_handshake_arbiter (size = 4).
//
// Each vector drives req_in and ack_out one time unit after a rising edge.
// The vector also pushes its expected {req_out, ack_in, grant_idx, busy} onto
// a scoreboard queue. After one transition latency the bench pops the queue
// and compares the expected values with the DUT outputs. Every vector is
// chosen so that the expected state holds at the sampling point.

`timescale 1ns/1ps

module tb_rr_handshake_arbiter;

`ifdef ARB_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    string      name;
    logic [3:0] req;
    logic       ack;
    logic       exp_req_out;
    logic [3:0] exp_ack_in;
    logic [1:0] exp_grant;
    logic       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_in = '0;
  logic [3:0] ack_in;
  logic       req_out;
  logic       ack_out = 1'b0;
  logic [1:0] grant_idx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  vec_t exp_q[$];
  vec_t table_v[38];

  rr_handshake_arbiter #(.size(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .ack_in    (ack_in),
    .req_out   (req_out),
    .ack_out   (ack_out),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bounds the whole run in case the sequence stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string n, logic [3:0] r, logic a, logic ro,
                              logic [3:0] ai, logic [1:0] g, logic b);
    vec_t v;
    v.name = n; v.req = r; v.ack = a;
    v.exp_req_out = ro; v.exp_ack_in = ai; v.exp_grant = g; v.exp_busy = b;
    return v;
  endfunction

  task automatic compare(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = exp_q.pop_front();
    compare({e.name, ".req_out"},   32'(req_out),   32'(e.exp_req_out));
    compare({e.name, ".ack_in"},    32'(ack_in),    32'(e.exp_ack_in));
    compare({e.name, ".grant_idx"}, 32'(grant_idx), 32'(e.exp_grant));
    compare({e.name, ".busy"},      32'(busy),      32'(e.exp_busy));
    compare({e.name, ".ack_onehot"}, 32'($countones(ack_in) <= 1), 32'd1);
  endtask

  // Called one time unit after a rising edge. The inputs change off-edge,
  // and the outputs are sampled one time unit after the edge that is LAT
  // edges later.
  task automatic applyStimulus(input vec_t v);
    req_in  = v.req;
    ack_out = v.ack;
    exp_q.push_back(v);
    repeat (LAT) @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Asserts reset mid-cycle and checks the outputs in the same cycle. Then
  // releases reset one time unit after the next edge.
  task automatic resetCheck(input string n);
    rst = 1'b1;
    #1;
    exp_q.push_back(mk(n, req_in, ack_out, 1'b0, 4'b0000, 2'd0, 1'b0));
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;
    logic [1:0] w;

    // {name, req_in, ack_out, exp req_out, exp ack_in, exp grant_idx, exp busy}
    table_v[0]  = mk("single_grant",     4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1);
    table_v[1]  = mk("single_wait",      4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1);
    table_v[2]  = mk("single_ackd",      4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    table_v[3]  = mk("single_release",   4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1);
    table_v[4]  = mk("single_idle",      4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0);
    table_v[5]  = mk("prio_grant2",      4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1);
    table_v[6]  = mk("prio_pending",     4'b1101, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1);
    table_v[7]  = mk("prio_ackd2",       4'b1101, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    table_v[8]  = mk("prio_release2",    4'b1001, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1);
    table_v[9]  = mk("prio_idle2",       4'b1001, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0);
    table_v[10] = mk("prio_grant3",      4'b1001, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1);
    table_v[11] = mk("prio_ackd3",       4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1);
    table_v[12] = mk("prio_release3",    4'b0001, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1);
    table_v[13] = mk("prio_idle3",       4'b0001, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0);
    table_v[14] = mk("prio_grant0",      4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1);
    table_v[15] = mk("prio_ackd0",       4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    table_v[16] = mk("prio_release0",    4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1);
    table_v[17] = mk("prio_idle0",       4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    table_v[18] = mk("late_grant3",      4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1);
    table_v[19] = mk("late_req1",        4'b1010, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1);
    table_v[20] = mk("late_ackd3",       4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1);
    table_v[21] = mk("late_release3",    4'b0010, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1);
    table_v[22] = mk("late_idle_noack1", 4'b0010, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0);
    table_v[23] = mk("late_grant1",      4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1);
    table_v[24] = mk("late_ackd1",       4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
    table_v[25] = mk("late_release1",    4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
    table_v[26] = mk("late_idle1",       4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0);
    table_v[27] = mk("viol_grant0",      4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1);
    table_v[28] = mk("viol_rq_drop",     4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1);
    table_v[29] = mk("viol_ackd0",       4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    table_v[30] = mk("viol_release0",    4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1);
    table_v[31] = mk("viol_idle0",       4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    table_v[32] = mk("chan_grant1",      4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1);
    table_v[33] = mk("chan_ackd1",       4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
    table_v[34] = mk("chan_ak_drop",     4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1);
    table_v[35] = mk("chan_ak_back",     4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
    table_v[36] = mk("chan_release1",    4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
    table_v[37] = mk("chan_idle1",       4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0);

    @(posedge clk);
    #1;
    resetCheck("reset_initial");

    for (int i = 0; i < 38; i++) applyStimulus(table_v[i]);

    // Reset in the middle of a GRANT. The pointer is 1 here, so requester 1
    // wins. After reset, requester 1 wins again from the reset pointer.
    applyStimulus(mk("rst_pre_grant1", 4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1));
    resetCheck("rst_mid_grant");
    applyStimulus(mk("rst_post_grant1", 4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1));
    applyStimulus(mk("rst_post_ackd1",  4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1));
    applyStimulus(mk("rst_post_rel1",   4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1));
    applyStimulus(mk("rst_post_idle1",  4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0));

    // Rotation with every requester held high. Only the winner drops its
    // request, and it raises the request again on the next round.
    resetCheck("reset_rotation");
    for (int r = 0; r < 5; r++) begin
      w  = 2'(r % 4);
      oh = 4'b0001 << w;
      applyStimulus(mk($sformatf("rot%0d_grant", r),   4'b1111,       1'b0, 1'b1, 4'b0000, w, 1'b1));
      applyStimulus(mk($sformatf("rot%0d_ackd", r),    4'b1111,       1'b1, 1'b1, oh,      w, 1'b1));
      applyStimulus(mk($sformatf("rot%0d_release", r), 4'b1111 & ~oh, 1'b1, 1'b0, oh,      w, 1'b1));
      applyStimulus(mk($sformatf("rot%0d_idle", r),    4'b1111 & ~oh, 1'b0, 1'b0, 4'b0000, w, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
